instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Initiator side of the instruction-memory interface. Holds the PC and issues
//  word-aligned requests to instruction memory. Captures the returned words into
//  a small FIFO and presents {pc, instr} to decode with a valid/ready handshake.
//  Handles redirects (branch/jump) by flushing the FIFO and discarding in-flight data.
//  Sits between instruction memory and the decode stage of the core.
// PARAMETERS
//  RESET_PC    32'h0000_0000  first fetch address after reset
//  FIFO_DEPTH  2              fetch buffer entries (power of 2, >=2)
// PORTS
//  clk                 in   1   core clock
//  reset_n             in   1   asynchronous reset, active low
//  instr_mem_req_o     out  1   request valid to instruction memory
//  instr_mem_addr_o    out  32  request byte address, bits[1:0] always 0
//  instr_mem_gnt_i     in   1   memory accepts request this cycle
//  instr_mem_rvalid_i  in   1   response data valid (same cycle as gnt or later)
//  instr_mem_data_i    in   32  response instruction word
//  redirect_i          in   1   PC redirect (taken branch/jump) this cycle
//  redirect_pc_i       in   32  redirect target; bits[1:0] ignored (forced 0)
//  fetch_valid_o       out  1   {fetch_pc_o, fetch_instr_o} valid to decode
//  fetch_pc_o          out  32  PC of presented instruction
//  fetch_instr_o       out  32  presented instruction word
//  fetch_ready_i       in   1   decode accepts this cycle
// BEHAVIOUR
//  Reset (async, reset_n=0): pc_q=RESET_PC, FIFO empty, wait_q=0, drop_q=0;
//   fetch_valid_o=0, instr_mem_req_o=0, fetch_pc_o/fetch_instr_o=0.
//  Request state: IDLE (wait_q=0) / WAIT (wait_q=1, granted, no response yet).
//  instr_mem_req_o = !wait_q && (count_q < FIFO_DEPTH) && !redirect_i.
//   Pop in the same cycle does not open space for the request.
//  instr_mem_addr_o = pc_q. Request and address stay stable until gnt.
//  Grant (req && gnt): inflight_pc_q <= pc_q; pc_q <= pc_q + 4 (wraps mod 2^32).
//   If rvalid is not seen in the grant cycle, go to WAIT.
//  Response (rvalid while granted/WAIT, drop_q=0, no redirect): push {inflight_pc, data}.
//   Then go to IDLE. rvalid while IDLE with no grant is ignored.
//   Zero-latency memory: gnt and rvalid in the same cycle is legal.
//  Memory rule: at most one request outstanding. Responses are in order.
//  Output: FIFO head is registered. Push->fetch_valid_o latency is 1 cycle.
//   Sustained throughput is 1 instr/cycle with zero-latency memory and
//   fetch_ready_i=1.
//  Handshake: pop on fetch_valid_o && fetch_ready_i. Outputs hold while valid && !ready.
//  Simultaneous push and pop: count unchanged. Push when full cannot occur
//   because of the req gating.
//  Redirect (redirect_i=1):
//   - FIFO flushed at the clock edge; fetch_valid_o=0 next cycle.
//   - pc_q <= {redirect_pc_i[31:2],2'b00}. No request is issued in the redirect cycle.
//   - An rvalid in the redirect cycle is discarded.
//   - If WAIT and no rvalid in the redirect cycle, drop_q<=1.
//     The next rvalid is discarded and clears drop_q and wait_q.
//     The new request is issued from the following cycle.
//   - Redirect has priority over push, pop and grant in the same cycle.
//   - Back-to-back redirects: the last redirect wins.
//  Reset mid-operation: the outstanding request is abandoned. After reset
//   release, the first req targets RESET_PC. Memory must also be reset.
// TESTING
//  1 reset release, gnt=rvalid=1 every cycle, ready=1 -> addr 0,4,8,...
//    fetch_valid_o from cycle 2, one instr/cycle, pc 0,4,8.
//  2 ready=0 with zero-latency memory -> 2 entries buffered, then req_o=0.
//    Outputs hold pc=0. Raising ready drains pc 0,4,8 in order.
//  3 memory with gnt then rvalid 3 cycles later -> req_o low while WAIT.
//    One instr per 4 cycles. Data matches the addressed word.
//  4 redirect_i with target 0x0000_0103 while WAIT -> next addr 0x100.
//    The stale response is dropped. The first presented pc is 0x100.
//  5 redirect in the same cycle as a pop and an rvalid -> FIFO empty next cycle.
//    No stale pc is presented. Next req addr is the target.
//  6 RESET_PC=32'hFFFF_FFF8, zero-latency memory -> addr FFFF_FFF8, FFFF_FFFC, 0000_0000.
//    Reset asserted mid-WAIT -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, issues one word request at a time to
// instruction memory, buffers returned words and hands {pc, instr} to decode.
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        instr_mem_req_o,
    output logic [31:0] instr_mem_addr_o,
    input  logic        instr_mem_gnt_i,
    input  logic        instr_mem_rvalid_i,
    input  logic [31:0] instr_mem_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_pc_o,
    output logic [31:0] fetch_instr_o,
    input  logic        fetch_ready_i
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // IDLE: free to request; WAIT: granted, response pending;
    // DROP: response pending but belongs to a redirected-away path
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } req_state_e;

    req_state_e         state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        inflight_pc_q, inflight_pc_d;

    fetch_entry_t       mem_q [FIFO_DEPTH];
    fetch_entry_t       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   rd_next;
    logic [CNT_W-1:0]   count_q, count_d;

    fetch_entry_t       head_q, head_d;
    logic               head_valid_q, head_valid_d;

    logic               req;
    logic               grant;
    logic               push;
    logic               pop;
    fetch_entry_t       push_entry;
    logic               unused_redirect_lsb;

    // Low target bits are forced to zero, so they never reach the PC
    assign unused_redirect_lsb = ^redirect_pc_i[1:0];

    // Request only with buffer space and no pending response; reset and redirect block it
    assign req   = reset_n && (state_q == ST_IDLE) &&
                   (count_q < CNT_W'(FIFO_DEPTH)) && !redirect_i;
    assign grant = req && instr_mem_gnt_i;
    assign pop   = head_valid_q && fetch_ready_i && !redirect_i;

    assign instr_mem_req_o  = req;
    assign instr_mem_addr_o = pc_q;
    assign fetch_valid_o    = head_valid_q;
    assign fetch_pc_o       = head_q.pc;
    assign fetch_instr_o    = head_q.instr;

    assign rd_next = PTR_W'(rd_ptr_q + 1'b1);

    // Request state machine, PC advance and response capture
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        push          = 1'b0;
        push_entry    = '0;
        if (redirect_i) begin
            pc_d = {redirect_pc_i[31:2], 2'b00};
            if (state_q != ST_IDLE) begin
                state_d = instr_mem_rvalid_i ? ST_IDLE : ST_DROP;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (grant) begin
                        inflight_pc_d = pc_q;
                        pc_d          = 32'(pc_q + 32'd4);
                        if (instr_mem_rvalid_i) begin
                            push       = 1'b1;
                            push_entry = '{pc: pc_q, instr: instr_mem_data_i};
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (instr_mem_rvalid_i) begin
                        push       = 1'b1;
                        push_entry = '{pc: inflight_pc_q, instr: instr_mem_data_i};
                        state_d    = ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (instr_mem_rvalid_i) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Fetch buffer bookkeeping and registered head for decode
    always_comb begin
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        head_d       = head_q;
        head_valid_d = head_valid_q;
        if (redirect_i) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            head_valid_d = 1'b0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = PTR_W'(wr_ptr_q + 1'b1);
            end
            if (pop) begin
                rd_ptr_d = rd_next;
            end
            count_d = CNT_W'(count_q + CNT_W'(push) - CNT_W'(pop));
            if (pop) begin
                if (count_q > CNT_W'(1)) begin
                    head_d       = mem_q[rd_next];
                    head_valid_d = 1'b1;
                end else if (push) begin
                    head_d       = push_entry;
                    head_valid_d = 1'b1;
                end else begin
                    head_valid_d = 1'b0;
                end
            end else if (!head_valid_q && push) begin
                head_d       = push_entry;
                head_valid_d = 1'b1;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            inflight_pc_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            head_q        <= '0;
            head_valid_q  <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            head_q        <= head_d;
            head_valid_q  <= head_valid_d;
            mem_q         <= mem_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, hand-written latency/redirect
// sequences, then randomized traffic against a program-order reference model.
module tb_instr_fetch;

    logic        clk;
    logic        reset_n;
    logic        gnt, rvalid, ready, redir, hi_en;
    logic [31:0] mem_data, redir_pc;
    logic        req, valid;
    logic [31:0] addr, f_pc, f_instr;
    logic        hi_req, hi_valid;
    logic [31:0] hi_addr, hi_pc, hi_instr, hi_data;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return 32'((a * 32'h9E37_79B1) ^ 32'h5A5A_1234);
    endfunction

    assign hi_data = instr_of(hi_addr);

    instr_fetch dut (
        .clk(clk), .reset_n(reset_n),
        .instr_mem_req_o(req), .instr_mem_addr_o(addr),
        .instr_mem_gnt_i(gnt), .instr_mem_rvalid_i(rvalid), .instr_mem_data_i(mem_data),
        .redirect_i(redir), .redirect_pc_i(redir_pc),
        .fetch_valid_o(valid), .fetch_pc_o(f_pc), .fetch_instr_o(f_instr),
        .fetch_ready_i(ready)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_hi (
        .clk(clk), .reset_n(reset_n),
        .instr_mem_req_o(hi_req), .instr_mem_addr_o(hi_addr),
        .instr_mem_gnt_i(hi_en), .instr_mem_rvalid_i(hi_en), .instr_mem_data_i(hi_data),
        .redirect_i(1'b0), .redirect_pc_i(32'h0),
        .fetch_valid_o(hi_valid), .fetch_pc_o(hi_pc), .fetch_instr_o(hi_instr),
        .fetch_ready_i(1'b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    // memory responder state
    bit          tbl_mode;
    bit          spur_en;
    int unsigned gnt_pct, lat_min, lat_max, next_lat;
    bit          pend_v;
    int unsigned pend_cnt;
    logic [31:0] pend_addr;

    // per-cycle samples
    bit          s_req, s_gnt, s_valid, s_pend, s_hi_valid;
    logic [31:0] s_addr, s_pc, s_instr, s_hi_addr, s_hi_pc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        ready = 1'b0; redir = 1'b0; redir_pc = '0;
        gnt = 1'b0; rvalid = 1'b0; mem_data = '0; hi_en = 1'b0;
        pend_v = 1'b0; pend_cnt = 0;
        next_lat = $urandom_range(lat_max, lat_min);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One clock cycle: drive inputs, let memory respond, sample, advance
    task automatic cycle(input bit rdy, input bit rd, input logic [31:0] tgt);
        @(negedge clk);
        ready = rdy; redir = rd; redir_pc = tgt; hi_en = 1'b1;
        #1;
        if (tbl_mode) begin
            gnt = 1'b1; rvalid = 1'b1; mem_data = instr_of(addr);
        end else begin
            gnt = ($urandom_range(99) < gnt_pct);
            rvalid = 1'b0; mem_data = $urandom;
            if (pend_v && pend_cnt == 0) begin
                rvalid = 1'b1; mem_data = instr_of(pend_addr);
            end else if (!pend_v && req && gnt && next_lat == 0) begin
                rvalid = 1'b1; mem_data = instr_of(addr);
            end else if (!pend_v && !(req && gnt) && spur_en && $urandom_range(9) == 0) begin
                rvalid = 1'b1;
            end
        end
        #1;
        s_req = req; s_gnt = gnt; s_addr = addr; s_valid = valid;
        s_pc = f_pc; s_instr = f_instr; s_pend = pend_v;
        s_hi_addr = hi_addr; s_hi_valid = hi_valid; s_hi_pc = hi_pc;
        @(posedge clk);
        if (!tbl_mode) begin
            if (pend_v) begin
                if (pend_cnt == 0) pend_v = 1'b0;
                else pend_cnt--;
            end else if (s_req && s_gnt) begin
                if (next_lat != 0) begin
                    pend_v = 1'b1; pend_addr = s_addr; pend_cnt = next_lat - 1;
                end
                next_lat = $urandom_range(lat_max, lat_min);
            end
        end
    endtask

    typedef struct {
        bit          rst;
        bit          rdy;
        bit          rd;
        logic [31:0] tgt;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc;
    } vec_t;

    function automatic vec_t mk(bit rst, bit rdy, bit rd, logic [31:0] tgt,
                                bit er, logic [31:0] ea, bit ev, logic [31:0] ep);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.rd = rd; v.tgt = tgt;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        int unsigned k;
        int unsigned pops;
        logic [31:0] exp_pc, exp_req_addr;
        bit          rdy, rd, p_req, p_gnt, p_valid, p_rdy, p_redir;
        logic [31:0] tgt, p_addr, p_pc, p_instr;

        reset_n = 1'b0;
        ready = 1'b0; redir = 1'b0; redir_pc = '0; gnt = 1'b0; rvalid = 1'b0;
        mem_data = '0; hi_en = 1'b0;
        tbl_mode = 1'b1; spur_en = 1'b0; gnt_pct = 100; lat_min = 0; lat_max = 0;
        k = 0;

        // streaming with zero-latency memory, ready high
        tbl.push_back(mk(1, 1, 0, 0,        1, 32'h00,  0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 0,        1, 32'h04,  1, 32'h0));
        tbl.push_back(mk(0, 1, 0, 0,        1, 32'h08,  1, 32'h4));
        tbl.push_back(mk(0, 1, 0, 0,        1, 32'h0C,  1, 32'h8));
        // backpressure fills buffer, then drain; then redirect during pop+rvalid
        tbl.push_back(mk(1, 0, 0, 0,        1, 32'h00,  0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0,        1, 32'h04,  1, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0,        0, 32'h08,  1, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0,        0, 32'h08,  1, 32'h0));
        tbl.push_back(mk(0, 1, 0, 0,        0, 32'h08,  1, 32'h0));
        tbl.push_back(mk(0, 1, 0, 0,        1, 32'h08,  1, 32'h4));
        tbl.push_back(mk(0, 1, 0, 0,        1, 32'h0C,  1, 32'h8));
        tbl.push_back(mk(0, 1, 0, 0,        1, 32'h10,  1, 32'hC));
        tbl.push_back(mk(0, 1, 1, 32'h203,  0, 32'h14,  1, 32'h10));
        tbl.push_back(mk(0, 1, 0, 0,        1, 32'h200, 0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 0,        1, 32'h204, 1, 32'h200));

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) begin
                do_reset();
                k = 0;
            end
            cycle(tbl[i].rdy, tbl[i].rd, tbl[i].tgt);
            chk($sformatf("tbl%0d req", i), 32'(s_req), 32'(tbl[i].e_req));
            chk($sformatf("tbl%0d addr", i), s_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d valid", i), 32'(s_valid), 32'(tbl[i].e_valid));
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d pc", i), s_pc, tbl[i].e_pc);
                chk($sformatf("tbl%0d instr", i), s_instr, instr_of(tbl[i].e_pc));
            end
            chk($sformatf("tbl%0d hi addr", i), s_hi_addr, 32'(32'hFFFF_FFF8 + 4 * k));
            chk($sformatf("tbl%0d hi valid", i), 32'(s_hi_valid), 32'(k != 0));
            if (k != 0) chk($sformatf("tbl%0d hi pc", i), s_hi_pc, 32'(32'hFFFF_FFF8 + 4 * (k - 1)));
            k++;
        end

        // slow memory: response 3 cycles after grant, one instr per 4 cycles
        tbl_mode = 1'b0; lat_min = 3; lat_max = 3; gnt_pct = 100;
        do_reset();
        for (int c = 0; c < 13; c++) begin
            cycle(1'b1, 1'b0, 32'h0);
            chk($sformatf("slow c%0d req", c), 32'(s_req), 32'(c % 4 == 0));
            if (c % 4 == 0) chk($sformatf("slow c%0d addr", c), s_addr, 32'(4 * (c / 4)));
            chk($sformatf("slow c%0d valid", c), 32'(s_valid), 32'(c % 4 == 0 && c > 0));
            if (c % 4 == 0 && c > 0) begin
                chk($sformatf("slow c%0d pc", c), s_pc, 32'(4 * (c / 4 - 1)));
                chk($sformatf("slow c%0d instr", c), s_instr, instr_of(32'(4 * (c / 4 - 1))));
            end
        end

        // asynchronous reset while a response is outstanding
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async req", 32'(req), 32'h0);
        chk("async addr", addr, 32'h0);
        chk("async valid", 32'(valid), 32'h0);
        chk("async pc", f_pc, 32'h0);
        chk("async instr", f_instr, 32'h0);
        chk("async hi req", 32'(hi_req), 32'h0);
        chk("async hi addr", hi_addr, 32'hFFFF_FFF8);
        pend_v = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // redirect while waiting: stale response dropped, fetch restarts at target
        do_reset();
        cycle(1'b1, 1'b0, 32'h0);
        chk("drop c0 req", 32'(s_req), 32'h1);
        chk("drop c0 addr", s_addr, 32'h0);
        cycle(1'b1, 1'b1, 32'h0000_0103);
        chk("drop c1 req", 32'(s_req), 32'h0);
        for (int c = 2; c < 4; c++) begin
            cycle(1'b1, 1'b0, 32'h0);
            chk($sformatf("drop c%0d req", c), 32'(s_req), 32'h0);
            chk($sformatf("drop c%0d valid", c), 32'(s_valid), 32'h0);
        end
        cycle(1'b1, 1'b0, 32'h0);
        chk("drop c4 req", 32'(s_req), 32'h1);
        chk("drop c4 addr", s_addr, 32'h100);
        for (int c = 5; c < 8; c++) begin
            cycle(1'b1, 1'b0, 32'h0);
            chk($sformatf("drop c%0d valid", c), 32'(s_valid), 32'h0);
        end
        cycle(1'b1, 1'b0, 32'h0);
        chk("drop c8 valid", 32'(s_valid), 32'h1);
        chk("drop c8 pc", s_pc, 32'h100);
        chk("drop c8 instr", s_instr, instr_of(32'h100));

        // randomized traffic against the program-order model
        lat_min = 0; lat_max = 3; gnt_pct = 70; spur_en = 1'b1;
        do_reset();
        exp_pc = 32'h0; exp_req_addr = 32'h0; pops = 0;
        p_req = 0; p_gnt = 0; p_valid = 0; p_rdy = 0; p_redir = 0;
        p_addr = '0; p_pc = '0; p_instr = '0;
        for (int c = 0; c < 3000; c++) begin
            rdy = ($urandom_range(3) != 0);
            rd  = ($urandom_range(24) == 0);
            tgt = $urandom;
            cycle(rdy, rd, tgt);
            if (s_req) begin
                chk("rand addr align", 32'(s_addr[1:0]), 32'h0);
                chk("rand req addr", s_addr, exp_req_addr);
            end
            if (s_pend) chk("rand one outstanding", 32'(s_req), 32'h0);
            if (p_req && !p_gnt && !rd) begin
                chk("rand req stable", 32'(s_req), 32'h1);
                chk("rand addr stable", s_addr, p_addr);
            end
            if (p_valid && !p_rdy && !p_redir) begin
                chk("rand hold valid", 32'(s_valid), 32'h1);
                chk("rand hold pc", s_pc, p_pc);
                chk("rand hold instr", s_instr, p_instr);
            end
            if (p_redir) chk("rand flush", 32'(s_valid), 32'h0);
            if (s_valid && rdy && !rd) begin
                chk("rand pop pc", s_pc, exp_pc);
                chk("rand pop instr", s_instr, instr_of(exp_pc));
                exp_pc = 32'(exp_pc + 32'd4);
                pops++;
            end
            if (rd) begin
                exp_pc       = {tgt[31:2], 2'b00};
                exp_req_addr = {tgt[31:2], 2'b00};
            end else if (s_req && s_gnt) begin
                exp_req_addr = 32'(exp_req_addr + 32'd4);
            end
            p_req = s_req; p_gnt = s_gnt; p_addr = s_addr; p_valid = s_valid;
            p_pc = s_pc; p_instr = s_instr; p_rdy = rdy; p_redir = rd;
        end
        chk("rand progress", 32'(pops > 200), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
